mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rstn  in  1  reset, asynchronous, active-low.
REQ-003 Op  in  6  opcode field of the instruction register.
REQ-004 Funct  in  6  funct field of the instruction register.
REQ-005 Zero  in  1  ALU zero flag.
REQ-006 MemAck  in  1  memory completion; the access finishes in the cycle it is high.
REQ-007 MemReq  out  1  memory access request, held until MemAck.
REQ-008 MemWrite  out  1  qualifies MemReq as a store.
REQ-009 IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 IRWrite  out  1  instruction register load enable.
REQ-011 PCWrite  out  1  PC load enable.
REQ-012 PCSource  out  2  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = RD1.
REQ-013 RegWrite  out  1  register file write enable.
REQ-014 RegDst  out  2  destination select: 0 = rt, 1 = rd, 2 = r31.
REQ-015 WDSel  out  2  write data select: 0 = ALUOut, 1 = MDR, 2 = PC.
REQ-016 ALUSrcA  out  2  ALU A select: 0 = PC, 1 = RD1, 2 = shamt.
REQ-017 ALUSrcB  out  2  ALU B select: 0 = RD2, 1 = 4, 2 = ext imm, 3 = ext imm<<2.
REQ-018 ALUOp  out  4  ALU operation code from the shared header.
REQ-019 EXTOp  out  1  immediate extension: 1 = sign, 0 = zero (andi, ori).
REQ-020 Illegal  out  1  one-cycle pulse in ID on an unsupported Op/Funct.
REQ-021 State  out  4  current FSM state, for debug.

Function
REQ-022 The FSM SHALL have these states: IF=0, ID=1, EXR=2, EXI=3, MA=4, MR=5, MW=6, WBR=7, WBI=8, WBM=9, BR=10.
- Codes 11-15 are unreachable and SHALL recover to IF.
REQ-023 Outputs SHALL be combinational from State, Op, Funct, Zero and MemAck.
- Any output not listed for a state SHALL be 0.
REQ-024 IF: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD.
- When MemAck=1: IRWrite=1, PCWrite=1, PCSource=0, and the next state is ID.
- When MemAck=0: stay in IF with no writes.
REQ-025 ID: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (branch target into ALUOut). Next state by instruction:
- R-type (except jr) -> EXR
- addi/andi/ori/slti/lui -> EXI
- lw/sw -> MA
- beq/bne -> BR
REQ-026 ID, jump instructions: finish in ID and next state is IF.
- j: PCWrite=1, PCSource=2.
- jal: as j, plus RegWrite=1, RegDst=2, WDSel=2.
- jr: PCWrite=1, PCSource=3.
REQ-027 ID, illegal instruction: Illegal=1, next state IF, no register or memory write.
REQ-028 EXR: ALUSrcA=1, ALUSrcB=0, ALUOp from decode; next state WBR.
- sll/srl SHALL use ALUSrcA=2.
REQ-029 EXI: ALUSrcA=1, ALUSrcB=2, ALUOp from decode; next state WBI.
REQ-030 WBR: RegWrite=1, RegDst=1, WDSel=0.
- WBI: RegWrite=1, RegDst=0, WDSel=0.
- WBM: RegWrite=1, RegDst=0, WDSel=1.
- All three return to IF.
REQ-031 MA: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD, EXTOp=1.
- lw -> MR; sw -> MW.
REQ-032 MR/MW: MemReq=1, IorD=1; MemWrite=1 in MW only.
- Hold the state while MemAck=0.
- On MemAck: MR -> WBM, MW -> IF.
REQ-033 BR: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1.
- PCWrite = (beq & Zero) | (bne & ~Zero); next state IF.
REQ-034 MemAck=1 outside IF/MR/MW SHALL be ignored.
- MemReq SHALL never drop before MemAck.

Reset
REQ-035 rstn low SHALL asynchronously force State=IF, and every enable/request output SHALL read 0 while rstn is low.
REQ-036 Reset mid-access SHALL abandon the access.
- After release, fetch restarts in IF with MemReq=1 in the first cycle.

Structure
REQ-037 State codes and ALUOp codes SHALL live in the shared ctrl_encode_def header:
- NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, SLTU=6, NOR=7, SLL=8, SRL=9, LUI=10.
REQ-038 A combinational sub-module alu_dec (Op, Funct -> ALUOp, EXTOp, Illegal) SHALL hold all instruction decode.

Verification
REQ-039 add, MemAck tied high -> states IF, ID, EXR, WBR, IF; ALUOp=1 in EXR; RegDst=1 and RegWrite=1 in WBR.
REQ-040 lw, MemAck delayed 3 cycles in MR -> MR held 4 cycles with MemReq=1, then WBM with WDSel=1.
REQ-041 beq with Zero=1 -> PCWrite=1, PCSource=1 in BR; bne with Zero=1 -> PCWrite=0.
REQ-042 jal -> in ID: PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, WDSel=2; next state IF.
REQ-043 Op=6'h3f -> Illegal pulses one cycle in ID; no RegWrite or MemWrite; next state IF.
REQ-044 rstn pulled low during MW -> State=0 immediately and MemWrite=0; after release, IF with MemReq=1.

Source files
------------

// File: rtl/ctrl_encode_def.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_encode_def (package)
//  Description : Shared encodings for the multicycle controller: FSM state
//                codes, ALU operation codes, instruction classes and the
//                MIPS opcode/funct values recognised by the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_encode_def;

    // FSM state codes (4 bits; codes 11-15 unused)
    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EXR = 4'd2,
        S_EXI = 4'd3,
        S_MA  = 4'd4,
        S_MR  = 4'd5,
        S_MW  = 4'd6,
        S_WBR = 4'd7,
        S_WBI = 4'd8,
        S_WBM = 4'd9,
        S_BR  = 4'd10
    } state_e;

    // ALU operation codes seen on ALUOp
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    // Instruction classes: select the path the FSM takes out of ID
    typedef enum logic [2:0] {
        IC_RTYPE   = 3'd0,
        IC_ITYPE   = 3'd1,
        IC_MEM     = 3'd2,
        IC_BRANCH  = 3'd3,
        IC_J       = 3'd4,
        IC_JAL     = 3'd5,
        IC_JR      = 3'd6,
        IC_ILLEGAL = 3'd7
    } instr_class_e;

    // Opcodes
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_slti  = 6'h0a;
    localparam logic [5:0] c_op_andi  = 6'h0c;
    localparam logic [5:0] c_op_ori   = 6'h0d;
    localparam logic [5:0] c_op_lui   = 6'h0f;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_srl  = 6'h02;
    localparam logic [5:0] c_fn_jr   = 6'h08;
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_nor  = 6'h27;
    localparam logic [5:0] c_fn_slt  = 6'h2a;
    localparam logic [5:0] c_fn_sltu = 6'h2b;

endpackage
`default_nettype wire

// File: rtl/alu_dec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_dec
//  Description : Purely combinational instruction decoder. Maps Op/Funct to
//                the ALU operation, immediate extension mode, an illegal
//                flag and the instruction class used by the FSM.
//  Revision    : 1.0 - initial release
//  Ports       : Op, Funct      - instruction fields
//                ALUOp          - ALU operation for the execute states
//                EXTOp          - 1 = sign extend, 0 = zero extend
//                Illegal        - unsupported Op/Funct
//                instr_class    - control path selector for the FSM
//                is_shift       - sll/srl (ALU A from shamt)
//                is_load        - lw (vs sw) for the memory path
//                is_bne         - bne (vs beq) for the branch path
// ============================================================================
module alu_dec
    import ctrl_encode_def::*;
(
    input  logic [5:0]   Op,
    input  logic [5:0]   Funct,
    output alu_op_e      ALUOp,
    output logic         EXTOp,
    output logic         Illegal,
    output instr_class_e instr_class,
    output logic         is_shift,
    output logic         is_load,
    output logic         is_bne
);

    always_comb begin
        ALUOp       = ALU_NOP;
        EXTOp       = 1'b1;
        instr_class = IC_ILLEGAL;
        is_shift    = 1'b0;
        is_load     = 1'b0;
        is_bne      = 1'b0;

        case (Op)
            c_op_rtype: begin
                instr_class = IC_RTYPE;
                case (Funct)
                    c_fn_add, c_fn_addu: ALUOp = ALU_ADD;
                    c_fn_sub, c_fn_subu: ALUOp = ALU_SUB;
                    c_fn_and:            ALUOp = ALU_AND;
                    c_fn_or:             ALUOp = ALU_OR;
                    c_fn_nor:            ALUOp = ALU_NOR;
                    c_fn_slt:            ALUOp = ALU_SLT;
                    c_fn_sltu:           ALUOp = ALU_SLTU;
                    c_fn_sll: begin
                        ALUOp    = ALU_SLL;
                        is_shift = 1'b1;
                    end
                    c_fn_srl: begin
                        ALUOp    = ALU_SRL;
                        is_shift = 1'b1;
                    end
                    c_fn_jr:             instr_class = IC_JR;
                    default:             instr_class = IC_ILLEGAL;
                endcase
            end
            c_op_addi: begin
                instr_class = IC_ITYPE;
                ALUOp       = ALU_ADD;
            end
            c_op_slti: begin
                instr_class = IC_ITYPE;
                ALUOp       = ALU_SLT;
            end
            c_op_andi: begin
                instr_class = IC_ITYPE;
                ALUOp       = ALU_AND;
                EXTOp       = 1'b0;
            end
            c_op_ori: begin
                instr_class = IC_ITYPE;
                ALUOp       = ALU_OR;
                EXTOp       = 1'b0;
            end
            c_op_lui: begin
                instr_class = IC_ITYPE;
                ALUOp       = ALU_LUI;
            end
            c_op_lw: begin
                instr_class = IC_MEM;
                ALUOp       = ALU_ADD;
                is_load     = 1'b1;
            end
            c_op_sw: begin
                instr_class = IC_MEM;
                ALUOp       = ALU_ADD;
            end
            c_op_beq: begin
                instr_class = IC_BRANCH;
                ALUOp       = ALU_SUB;
            end
            c_op_bne: begin
                instr_class = IC_BRANCH;
                ALUOp       = ALU_SUB;
                is_bne      = 1'b1;
            end
            c_op_j:   instr_class = IC_J;
            c_op_jal: instr_class = IC_JAL;
            default:  instr_class = IC_ILLEGAL;
        endcase

        Illegal = (instr_class == IC_ILLEGAL);
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl
//  Description : Multicycle MIPS-style controller. An 11-state FSM sequences
//                fetch, decode, execute, memory and write-back; datapath
//                controls are decoded combinationally from the current state,
//                the instruction fields, Zero and MemAck.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rstn (async, active-low)
//                Op, Funct, Zero, MemAck                     - inputs
//                MemReq, MemWrite, IorD                      - memory side
//                IRWrite, PCWrite, PCSource                  - IR / PC
//                RegWrite, RegDst, WDSel                     - register file
//                ALUSrcA, ALUSrcB, ALUOp, EXTOp              - ALU / extender
//                Illegal, State                              - status / debug
// ============================================================================
module mc_ctrl
    import ctrl_encode_def::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemAck,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic       EXTOp,
    output logic       Illegal,
    output logic [3:0] State
);

    state_e       r_state;
    alu_op_e      w_alu_op;
    logic         w_ext_op;
    logic         w_illegal;
    instr_class_e w_class;
    logic         w_is_shift;
    logic         w_is_load;
    logic         w_is_bne;

    alu_dec u_alu_dec (
        .Op          (Op),
        .Funct       (Funct),
        .ALUOp       (w_alu_op),
        .EXTOp       (w_ext_op),
        .Illegal     (w_illegal),
        .instr_class (w_class),
        .is_shift    (w_is_shift),
        .is_load     (w_is_load),
        .is_bne      (w_is_bne)
    );

    assign State = r_state;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IF;
        end else begin
            case (r_state)
                S_IF:  if (MemAck) r_state <= S_ID;
                S_ID: begin
                    case (w_class)
                        IC_RTYPE:  r_state <= S_EXR;
                        IC_ITYPE:  r_state <= S_EXI;
                        IC_MEM:    r_state <= S_MA;
                        IC_BRANCH: r_state <= S_BR;
                        // jumps complete in ID; illegal ops are dropped
                        default:   r_state <= S_IF;
                    endcase
                end
                S_EXR: r_state <= S_WBR;
                S_EXI: r_state <= S_WBI;
                S_MA:  r_state <= w_is_load ? S_MR : S_MW;
                S_MR:  if (MemAck) r_state <= S_WBM;
                S_MW:  if (MemAck) r_state <= S_IF;
                S_WBR, S_WBI, S_WBM, S_BR: r_state <= S_IF;
                // unused codes fall back to fetch
                default: r_state <= S_IF;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control outputs. Everything is held at 0 while rstn is low so that
    // an aborted access cannot leave a request or write enable asserted.
    // ------------------------------------------------------------------
    always_comb begin
        MemReq   = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSource = 2'd0;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        WDSel    = 2'd0;
        ALUSrcA  = 2'd0;
        ALUSrcB  = 2'd0;
        ALUOp    = ALU_NOP;
        EXTOp    = 1'b0;
        Illegal  = 1'b0;

        if (rstn) begin
            case (r_state)
                S_IF: begin
                    // PC + 4 computed in parallel with the fetch
                    MemReq  = 1'b1;
                    ALUSrcB = 2'd1;
                    ALUOp   = ALU_ADD;
                    if (MemAck) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                S_ID: begin
                    // Branch target (PC + (sext imm << 2)) lands in ALUOut
                    ALUSrcB = 2'd3;
                    ALUOp   = ALU_ADD;
                    EXTOp   = 1'b1;
                    case (w_class)
                        IC_J: begin
                            PCWrite  = 1'b1;
                            PCSource = 2'd2;
                        end
                        IC_JAL: begin
                            PCWrite  = 1'b1;
                            PCSource = 2'd2;
                            RegWrite = 1'b1;
                            RegDst   = 2'd2;
                            WDSel    = 2'd2;
                        end
                        IC_JR: begin
                            PCWrite  = 1'b1;
                            PCSource = 2'd3;
                        end
                        default: ;
                    endcase
                    Illegal = w_illegal;
                end
                S_EXR: begin
                    ALUSrcA = w_is_shift ? 2'd2 : 2'd1;
                    ALUSrcB = 2'd0;
                    ALUOp   = w_alu_op;
                end
                S_EXI: begin
                    ALUSrcA = 2'd1;
                    ALUSrcB = 2'd2;
                    ALUOp   = w_alu_op;
                    EXTOp   = w_ext_op;
                end
                S_MA: begin
                    ALUSrcA = 2'd1;
                    ALUSrcB = 2'd2;
                    ALUOp   = ALU_ADD;
                    EXTOp   = 1'b1;
                end
                S_MR: begin
                    MemReq = 1'b1;
                    IorD   = 1'b1;
                end
                S_MW: begin
                    MemReq   = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_WBR: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd1;
                end
                S_WBI: begin
                    RegWrite = 1'b1;
                end
                S_WBM: begin
                    RegWrite = 1'b1;
                    WDSel    = 2'd1;
                end
                S_BR: begin
                    ALUSrcA  = 2'd1;
                    ALUOp    = ALU_SUB;
                    PCSource = 2'd1;
                    PCWrite  = w_is_bne ? ~Zero : Zero;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl
//  Description : Directed self-checking bench for mc_ctrl. Each step drives
//                instruction fields, waits for a clock edge and checks the
//                state and control outputs against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    logic       clk;
    logic       rstn;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemAck;
    logic       MemReq;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] WDSel;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic       EXTOp;
    logic       Illegal;
    logic [3:0] State;

    int tests;
    int failed;

    mc_ctrl dut (
        .clk      (clk),
        .rstn     (rstn),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .MemAck   (MemAck),
        .MemReq   (MemReq),
        .MemWrite (MemWrite),
        .IorD     (IorD),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .PCSource (PCSource),
        .RegWrite (RegWrite),
        .RegDst   (RegDst),
        .WDSel    (WDSel),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .EXTOp    (EXTOp),
        .Illegal  (Illegal),
        .State    (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rstn   = 1'b0;
        Op     = 6'h00;
        Funct  = 6'h20;
        Zero   = 1'b0;
        MemAck = 1'b1;

        // ---------------- reset ----------------
        #12;
        chk("rst_state",  8'(State), 8'd0);
        chk("rst_memreq", 8'(MemReq), 8'd0);
        chk("rst_irwrite",8'(IRWrite), 8'd0);
        #1 rstn = 1'b1;
        #1;
        chk("rel_memreq", 8'(MemReq), 8'd1);

        // ---------------- add, MemAck tied high ----------------
        // now in IF with MemAck=1
        chk("add_if_state", 8'(State), 8'd0);
        chk("add_if_irw",   8'(IRWrite), 8'd1);
        chk("add_if_pcw",   8'(PCWrite), 8'd1);
        chk("add_if_srcb",  8'(ALUSrcB), 8'd1);
        chk("add_if_aluop", 8'(ALUOp), 8'd1);
        step();
        chk("add_id_state", 8'(State), 8'd1);
        chk("add_id_srcb",  8'(ALUSrcB), 8'd3);
        step();
        chk("add_exr_state", 8'(State), 8'd2);
        chk("add_exr_aluop", 8'(ALUOp), 8'd1);
        chk("add_exr_srca",  8'(ALUSrcA), 8'd1);
        chk("add_exr_memreq",8'(MemReq), 8'd0);
        step();
        chk("add_wbr_state", 8'(State), 8'd7);
        chk("add_wbr_regw",  8'(RegWrite), 8'd1);
        chk("add_wbr_regdst",8'(RegDst), 8'd1);
        step();
        chk("add_back_if", 8'(State), 8'd0);

        // ---------------- sll: shamt into ALU A ----------------
        Funct = 6'h00;
        step(); step();
        chk("sll_exr_state", 8'(State), 8'd2);
        chk("sll_exr_srca",  8'(ALUSrcA), 8'd2);
        chk("sll_exr_aluop", 8'(ALUOp), 8'd8);
        step(); step();

        // ---------------- ori: zero extension ----------------
        Op = 6'h0d;
        step(); step();
        chk("ori_exi_state", 8'(State), 8'd3);
        chk("ori_exi_aluop", 8'(ALUOp), 8'd4);
        chk("ori_exi_ext",   8'(EXTOp), 8'd0);
        chk("ori_exi_srcb",  8'(ALUSrcB), 8'd2);
        step();
        chk("ori_wbi_state", 8'(State), 8'd8);
        chk("ori_wbi_regdst",8'(RegDst), 8'd0);
        step();

        // ---------------- lw, MemAck delayed 3 cycles ----------------
        Op = 6'h23;
        step();                                  // ID
        step();                                  // MA with MemAck still high
        chk("lw_ma_state",  8'(State), 8'd4);
        chk("lw_ma_memreq", 8'(MemReq), 8'd0);
        chk("lw_ma_ext",    8'(EXTOp), 8'd1);
        MemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lw_mr_wait_state",  8'(State), 8'd5);
            chk("lw_mr_wait_memreq", 8'(MemReq), 8'd1);
        end
        step();
        MemAck = 1'b1;
        #1;
        chk("lw_mr4_state", 8'(State), 8'd5);
        chk("lw_mr4_iord",  8'(IorD), 8'd1);
        step();
        chk("lw_wbm_state", 8'(State), 8'd9);
        chk("lw_wbm_wdsel", 8'(WDSel), 8'd1);
        chk("lw_wbm_regw",  8'(RegWrite), 8'd1);
        step();
        chk("lw_back_if", 8'(State), 8'd0);

        // ---------------- beq / bne with Zero=1 ----------------
        Op   = 6'h04;
        Zero = 1'b1;
        step(); step();
        chk("beq_br_state", 8'(State), 8'd10);
        chk("beq_br_pcw",   8'(PCWrite), 8'd1);
        chk("beq_br_pcsrc", 8'(PCSource), 8'd1);
        chk("beq_br_aluop", 8'(ALUOp), 8'd2);
        step();
        Op = 6'h05;
        step(); step();
        chk("bne_z1_pcw", 8'(PCWrite), 8'd0);
        Zero = 1'b0;
        #1;
        chk("bne_z0_pcw", 8'(PCWrite), 8'd1);
        step();

        // ---------------- jal ----------------
        Op = 6'h03;
        step();
        chk("jal_id_state",  8'(State), 8'd1);
        chk("jal_id_pcw",    8'(PCWrite), 8'd1);
        chk("jal_id_pcsrc",  8'(PCSource), 8'd2);
        chk("jal_id_regw",   8'(RegWrite), 8'd1);
        chk("jal_id_regdst", 8'(RegDst), 8'd2);
        chk("jal_id_wdsel",  8'(WDSel), 8'd2);
        step();
        chk("jal_next_if", 8'(State), 8'd0);

        // ---------------- jr ----------------
        Op    = 6'h00;
        Funct = 6'h08;
        step();
        chk("jr_id_pcsrc", 8'(PCSource), 8'd3);
        step();
        chk("jr_next_if", 8'(State), 8'd0);

        // ---------------- illegal opcode ----------------
        Op = 6'h3f;
        #1;
        chk("ill_if_noflag", 8'(Illegal), 8'd0);
        step();
        chk("ill_id_flag",  8'(Illegal), 8'd1);
        chk("ill_id_regw",  8'(RegWrite), 8'd0);
        chk("ill_id_memw",  8'(MemWrite), 8'd0);
        chk("ill_id_pcw",   8'(PCWrite), 8'd0);
        step();
        chk("ill_next_if",  8'(State), 8'd0);
        chk("ill_cleared",  8'(Illegal), 8'd0);

        // ---------------- sw with reset during MW ----------------
        Op = 6'h2b;
        step(); step();
        MemAck = 1'b0;
        step();
        chk("sw_mw_state", 8'(State), 8'd6);
        chk("sw_mw_memw",  8'(MemWrite), 8'd1);
        step();
        chk("sw_mw_hold",  8'(State), 8'd6);
        #2 rstn = 1'b0;
        #1;
        chk("sw_rst_state",  8'(State), 8'd0);
        chk("sw_rst_memw",   8'(MemWrite), 8'd0);
        chk("sw_rst_memreq", 8'(MemReq), 8'd0);
        step();
        #1 rstn = 1'b1;
        #1;
        chk("sw_rel_state",  8'(State), 8'd0);
        chk("sw_rel_memreq", 8'(MemReq), 8'd1);
        chk("sw_rel_iord",   8'(IorD), 8'd0);
        step();
        chk("sw_rel_hold_if", 8'(State), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // global watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
